si_seq_div_16by8: RTL



---
 rtl/si_seq_div_16by8_pkg.sv | 34 +++
 rtl/si_div_step.sv | 35 +++
 rtl/si_seq_div_16by8.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/si_seq_div_16by8_pkg.sv
// si_seq_div_16by8_pkg
//   Shared definitions for the sequential signed divider: FSM state encoding,
//   default operand width, the approximate-mode truncation constant, the
//   iteration/latency constant and the special-case result values.
//
// Build option: AP_DIV_TRUNC_EN selects approximate mode (fewer iterations,
//   low quotient bits forced to zero, remainder forced to zero).
package si_seq_div_16by8_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Default divisor/remainder width; dividend/quotient are twice this
  localparam int DEF_DW = 8;

  // Number of low quotient bits dropped in approximate mode
  localparam int APX = 4;

  // Clock edges from operand accept to out_valid for ordinary operands
`ifdef AP_DIV_TRUNC_EN
  localparam int LAT = 2 * DEF_DW - APX;
`else
  localparam int LAT = 2 * DEF_DW;
`endif

  // Special-case results at the default width
  localparam logic [2*DEF_DW-1:0] QUOT_ONES = {(2 * DEF_DW) {1'b1}};
  localparam logic [2*DEF_DW-1:0] MIN_NEG   = {1'b1, {(2 * DEF_DW - 1) {1'b0}}};

endpackage

// File: rtl/si_div_step.sv
// si_div_step
//   One combinational radix-2 restoring division iteration on magnitudes.
//
// Ports:
//   prem      in   DW+1  current partial remainder (always < dmag)
//   din       in   1     next dividend bit, shifted in at the bottom
//   dmag      in   DW+1  divisor magnitude (up to 2^DW)
//   prem_next out  DW+1  partial remainder after the trial subtraction
//   qbit      out  1     quotient bit produced by this iteration
module si_div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0] prem,
  input  logic        din,
  input  logic [DW:0] dmag,
  output logic [DW:0] prem_next,
  output logic        qbit
);

  logic [DW+1:0] shifted;
  logic [DW:0]   diff;
  logic          ge;

  // Shift in the next dividend bit and trial-subtract the divisor. Since the
  // incoming remainder is below dmag, a successful subtraction always fits
  // in DW+1 bits, so the low bits of the difference are the exact result.
  always_comb begin
    shifted   = {prem, din};
    ge        = (shifted >= {1'b0, dmag});
    diff      = shifted[DW:0] - dmag;
    prem_next = ge ? diff : shifted[DW:0];
    qbit      = ge;
  end

endmodule

// File: rtl/si_seq_div_16by8.sv
// si_seq_div_16by8
//   Sequential signed divider, the inverse of the signed 8x8 multiplier:
//   a 2*DW-bit signed dividend divided by a DW-bit signed divisor, one
//   quotient bit per clock, restoring algorithm on magnitudes with a sign
//   fix-up on the final edge. Quotient truncates toward zero; the remainder
//   takes the dividend's sign.
//
// Ports:
//   clk        in   1     clock, all state on rising edge
//   rst_n      in   1     synchronous active-low reset
//   in_valid   in   1     operands valid
//   in_ready   out  1     block can accept operands (IDLE only)
//   dividend   in   2*DW  signed dividend
//   divisor    in   DW    signed divisor
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer accepts result
//   quot       out  2*DW  signed quotient
//   rem        out  DW    signed remainder
//   dz         out  1     divide-by-zero flag, qualified by out_valid
//   ovf        out  1     overflow flag (-2^(2DW-1) / -1), qualified by out_valid
//
// Build option: AP_DIV_TRUNC_EN -> approximate mode: 2*DW-APX iterations,
//   low APX quotient magnitude bits forced to 0, remainder forced to 0.
module si_seq_div_16by8
  import si_seq_div_16by8_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quot,
  output logic [DW-1:0]   rem,
  output logic            dz,
  output logic            ovf
);

  localparam int QW = 2 * DW;
`ifdef AP_DIV_TRUNC_EN
  localparam int ITERS = QW - APX;
`else
  localparam int ITERS = QW;
`endif
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITERS - 1);
  localparam logic [QW-1:0] Q_ONES   = {QW{1'b1}};
  localparam logic [QW-1:0] Q_MINNEG = {1'b1, {(QW - 1) {1'b0}}};

  state_t        state;
  logic [QW-1:0] dvd_sh;
  logic [DW:0]   dvs_mag;
  logic [DW:0]   prem;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [CW-1:0] cnt;

  logic [QW-1:0] dvd_abs;
  logic [DW:0]   dvs_abs;
  logic [DW:0]   step_rem;
  logic          step_q;
  logic [QW-1:0] qbits_next;
  logic [QW-1:0] qmag;
  logic [QW-1:0] quot_fix;
  logic [DW-1:0] rem_fix;

  // Single restoring iteration; the dividend magnitude shifts out of the top
  // of dvd_sh while quotient bits shift in at the bottom.
  si_div_step #(
    .DW(DW)
  ) u_step (
    .prem     (prem),
    .din      (dvd_sh[QW-1]),
    .dmag     (dvs_mag),
    .prem_next(step_rem),
    .qbit     (step_q)
  );

  // Operand magnitudes. The divisor magnitude is DW+1 bits wide so that the
  // most negative divisor maps to +2^(DW-1) rather than wrapping. The most
  // negative dividend maps to 2^(QW-1), which is exact as an unsigned value.
  always_comb begin
    dvd_abs = dividend[QW-1] ? -dividend : dividend;
    dvs_abs = divisor[DW-1] ? -{1'b1, divisor} : {1'b0, divisor};
  end

  // Final-edge result: the last quotient bit joins the shift register, the
  // magnitude is optionally truncated, then signs are applied. In
  // approximate mode the bits produced so far are the top ITERS quotient
  // bits, so they are realigned above APX zero bits.
  always_comb begin
    qbits_next = {dvd_sh[QW-2:0], step_q};
`ifdef AP_DIV_TRUNC_EN
    qmag    = {qbits_next[ITERS-1:0], {APX{1'b0}}};
    rem_fix = '0;
`else
    qmag    = qbits_next;
    rem_fix = dvd_neg ? -step_rem[DW-1:0] : step_rem[DW-1:0];
`endif
    quot_fix = (dvd_neg ^ dvs_neg) ? -qmag : qmag;
  end

  // Control FSM and all registered outputs. Special operand cases skip CALC
  // and land in DONE on the accept edge. Results stay in quot/rem/dz/ovf
  // after the handshake until the next result overwrites them; reset at any
  // point discards work in flight and clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_sh   <= dvd_abs;
            dvs_mag  <= dvs_abs;
            dvd_neg  <= dividend[QW-1];
            dvs_neg  <= divisor[DW-1];
            prem     <= '0;
            cnt      <= CNT_INIT;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quot      <= Q_ONES;
              rem       <= '0;
              dz        <= 1'b1;
              ovf       <= 1'b0;
            end else if ((dividend == Q_MINNEG) && (divisor == '1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quot      <= Q_MINNEG;
              rem       <= '0;
              dz        <= 1'b0;
              ovf       <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem   <= step_rem;
          dvd_sh <= qbits_next;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quot      <= quot_fix;
            rem       <= rem_fix;
            dz        <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
